// File: rtl/simple_rx_checker.sv
// simple_rx_checker
//   Receives a throttled AXI4-Stream and checks each packet against a fixed
//   two-beat pattern: a header beat (TUSER[31:0] and TDATA) followed by a
//   second data beat carrying TLAST. Each packet is reported with a one-cycle
//   pkt_done/pkt_good pulse and accumulated into saturating statistics
//   counters.
//
//   Ports
//     S_AXI_ACLK, S_AXI_ARESET   clock, synchronous active-high reset
//     S_AXIS_T*                  stream slave (TREADY is the throttle output)
//     rst_cntrs                  clears counters and last_err while high
//     rx_pkt_count               packets completed
//     rx_good_count              packets that passed every check
//     rx_err_count               packets that failed any check
//     last_err                   {length, data/strobe, header} of the last failure
//     pkt_done, pkt_good         per-packet completion pulse and its verdict
//
//   FSM states
//     state      | meaning
//     ST_HEADER  | waiting for / checking the header beat (beat 0)
//     ST_SECOND  | checking beat 1, which must carry TLAST
//     ST_DRAIN   | packet already too long; discard beats up to TLAST

module simple_rx_checker #(
    parameter int                             C_S_AXIS_DATA_WIDTH  = 64,
    parameter int                             C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [31:0]                    C_EXP_TUSER          = 32'h04800040,
    parameter logic [C_S_AXIS_DATA_WIDTH-1:0] C_EXP_BEAT0          = {(C_S_AXIS_DATA_WIDTH/8){8'hAA}},
    parameter logic [C_S_AXIS_DATA_WIDTH-1:0] C_EXP_BEAT1          = '1,
    parameter int                             C_READY_PERIOD       = 1,
    parameter int                             C_CNT_WIDTH          = 32
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    input  logic                              rst_cntrs,
    output logic [C_CNT_WIDTH-1:0]            rx_pkt_count,
    output logic [C_CNT_WIDTH-1:0]            rx_good_count,
    output logic [C_CNT_WIDTH-1:0]            rx_err_count,
    output logic [2:0]                        last_err,
    output logic                              pkt_done,
    output logic                              pkt_good
);

    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_SECOND = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    // Throttle counter holds values 0..C_READY_PERIOD-1 (at most 15).
    localparam logic [3:0] THR_LAST = 4'(C_READY_PERIOD - 1);

    logic [3:0]             thr_q;
    state_e                 state_q;
    logic [2:0]             err_q;
    logic [2:0]             err_d;
    logic [2:0]             done_err_q;
    logic                   pkt_done_q;
    logic                   pkt_good_q;
    logic [C_CNT_WIDTH-1:0] pkt_cnt_q;
    logic [C_CNT_WIDTH-1:0] good_cnt_q;
    logic [C_CNT_WIDTH-1:0] err_cnt_q;
    logic [2:0]             last_err_q;
    logic                   accept;
    logic                   strb_full;
    logic                   unused_tuser;

    // Only TUSER[31:0] is checked; the remaining sideband bits are ignored.
    assign unused_tuser = ^S_AXIS_TUSER;

    function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // TREADY throttle
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            thr_q <= 4'd0;
        end else if (thr_q == THR_LAST) begin
            thr_q <= 4'd0;
        end else begin
            thr_q <= thr_q + 4'd1;
        end
    end

    assign S_AXIS_TREADY = (thr_q == 4'd0) && !S_AXI_ARESET;
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign strb_full     = &S_AXIS_TSTRB;

    // ------------------------------------------------------------------
    // Per-packet error flags including the beat being accepted this cycle
    // ------------------------------------------------------------------
    always_comb begin
        err_d = err_q;
        if (accept) begin
            case (state_q)
                ST_HEADER: begin
                    if (S_AXIS_TUSER[31:0] != C_EXP_TUSER) err_d[0] = 1'b1;
                    if ((S_AXIS_TDATA != C_EXP_BEAT0) || !strb_full) err_d[1] = 1'b1;
                    if (S_AXIS_TLAST) err_d[2] = 1'b1;
                end
                ST_SECOND: begin
                    if ((S_AXIS_TDATA != C_EXP_BEAT1) || !strb_full) err_d[1] = 1'b1;
                    if (!S_AXIS_TLAST) err_d[2] = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM with registered completion outputs
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q    <= ST_HEADER;
            err_q      <= 3'b000;
            done_err_q <= 3'b000;
            pkt_done_q <= 1'b0;
            pkt_good_q <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            pkt_good_q <= 1'b0;
            if (accept) begin
                if (S_AXIS_TLAST) begin
                    pkt_done_q <= 1'b1;
                    pkt_good_q <= (err_d == 3'b000);
                    done_err_q <= err_d;
                    err_q      <= 3'b000;
                    state_q    <= ST_HEADER;
                end else begin
                    err_q <= err_d;
                    case (state_q)
                        ST_HEADER: state_q <= ST_SECOND;
                        ST_SECOND: state_q <= ST_DRAIN;
                        ST_DRAIN:  state_q <= ST_DRAIN;
                        default:   state_q <= ST_HEADER;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics: updated at the close of the pkt_done cycle, so a
    // rst_cntrs pulse coinciding with pkt_done leaves everything at zero.
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || rst_cntrs) begin
            pkt_cnt_q  <= '0;
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
            last_err_q <= 3'b000;
        end else if (pkt_done_q) begin
            pkt_cnt_q <= sat_inc(pkt_cnt_q);
            if (pkt_good_q) begin
                good_cnt_q <= sat_inc(good_cnt_q);
            end else begin
                err_cnt_q  <= sat_inc(err_cnt_q);
                last_err_q <= done_err_q;
            end
        end
    end

    assign rx_pkt_count  = pkt_cnt_q;
    assign rx_good_count = good_cnt_q;
    assign rx_err_count  = err_cnt_q;
    assign last_err      = last_err_q;
    assign pkt_done      = pkt_done_q;
    assign pkt_good      = pkt_good_q;

endmodule

// File: tb/tb_simple_rx_checker.sv
module tb_simple_rx_checker;

    localparam logic [31:0]  TU_OK  = 32'h04800040;
    localparam logic [31:0]  TU_BAD = 32'h04800041;
    localparam logic [63:0]  B0     = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0]  B1     = 64'hFFFFFFFFFFFFFFFF;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // DUT with default parameters (TREADY always high)
    logic         rst = 1'b1;
    logic [63:0]  tdata = '0;
    logic [7:0]   tstrb = '0;
    logic [127:0] tuser = '0;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;
    logic         tready;
    logic         rst_cntrs = 1'b0;
    logic [31:0]  pkt_cnt, good_cnt, err_cnt;
    logic [2:0]   last_err;
    logic         pkt_done, pkt_good;

    simple_rx_checker dut (
        .S_AXI_ACLK(clk_sys), .S_AXI_ARESET(rst),
        .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TUSER(tuser),
        .S_AXIS_TVALID(tvalid), .S_AXIS_TLAST(tlast), .S_AXIS_TREADY(tready),
        .rst_cntrs(rst_cntrs),
        .rx_pkt_count(pkt_cnt), .rx_good_count(good_cnt), .rx_err_count(err_cnt),
        .last_err(last_err), .pkt_done(pkt_done), .pkt_good(pkt_good)
    );

    // DUT with a 1-in-4 throttle and 2-bit counters (saturation)
    logic         rst4 = 1'b1;
    logic [63:0]  tdata4 = '0;
    logic [127:0] tuser4 = '0;
    logic         tvalid4 = 1'b0;
    logic         tlast4 = 1'b0;
    logic         tready4;
    logic [1:0]   pkt_cnt4, good_cnt4, err_cnt4;
    logic [2:0]   last_err4;
    logic         pkt_done4, pkt_good4;

    simple_rx_checker #(.C_READY_PERIOD(4), .C_CNT_WIDTH(2)) dut4 (
        .S_AXI_ACLK(clk_sys), .S_AXI_ARESET(rst4),
        .S_AXIS_TDATA(tdata4), .S_AXIS_TSTRB(8'hFF), .S_AXIS_TUSER(tuser4),
        .S_AXIS_TVALID(tvalid4), .S_AXIS_TLAST(tlast4), .S_AXIS_TREADY(tready4),
        .rst_cntrs(1'b0),
        .rx_pkt_count(pkt_cnt4), .rx_good_count(good_cnt4), .rx_err_count(err_cnt4),
        .last_err(last_err4), .pkt_done(pkt_done4), .pkt_good(pkt_good4)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0, good_seen = 0, done4_seen = 0;

    always @(negedge clk_sys) begin
        if (pkt_done) begin
            done_seen++;
            if (pkt_good) good_seen++;
        end
        if (pkt_done4) done4_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] s, input logic [31:0] u, input logic l);
        @(negedge clk_sys);
        tdata  = d;
        tstrb  = s;
        tuser  = {96'h0, u};
        tlast  = l;
        tvalid = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk_sys);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic good_pkt();
        beat(B0, 8'hFF, TU_OK, 1'b0);
        beat(B1, 8'hFF, TU_OK, 1'b1);
    endtask

    // Present a beat on dut4 at a negedge where TREADY is high, so the next
    // rising edge accepts it. TVALID stays high between beats.
    task automatic beat4(input logic [63:0] d, input logic [31:0] u, input logic l);
        bit got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_sys);
            if (tready4) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("tready4_timeout", 64'd0, 64'd1);
        tdata4  = d;
        tuser4  = {96'h0, u};
        tlast4  = l;
        tvalid4 = 1'b1;
    endtask

    initial begin
        int d0;
        logic [7:0] pat;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk_sys);
        chk("rst_tready",   {63'd0, tready},   64'd0);
        chk("rst_pkt_done", {63'd0, pkt_done}, 64'd0);
        chk("rst_pkt_cnt",  {32'd0, pkt_cnt},  64'd0);
        chk("rst_last_err", {61'd0, last_err}, 64'd0);
        rst = 1'b0;
        #1 chk("tready_after_rst", {63'd0, tready}, 64'd1);

        // ---------------- two good packets back-to-back ----------------
        good_pkt();
        good_pkt();
        idle();
        idle();
        chk("b2b_done_pulses", done_seen, 2);
        chk("b2b_good_pulses", good_seen, 2);
        chk("b2b_pkt_cnt",  {32'd0, pkt_cnt},  64'd2);
        chk("b2b_good_cnt", {32'd0, good_cnt}, 64'd2);
        chk("b2b_err_cnt",  {32'd0, err_cnt},  64'd0);

        // ---------------- header TUSER mismatch ----------------
        beat(B0, 8'hFF, TU_BAD, 1'b0);
        beat(B1, 8'hFF, TU_OK, 1'b1);
        idle();
        chk("tuser_pkt_done", {63'd0, pkt_done}, 64'd1);
        chk("tuser_pkt_good", {63'd0, pkt_good}, 64'd0);
        idle();
        chk("tuser_pkt_done_1cyc", {63'd0, pkt_done}, 64'd0);
        chk("tuser_last_err", {61'd0, last_err}, 64'd1);
        chk("tuser_err_cnt",  {32'd0, err_cnt},  64'd1);

        // ---------------- strobe error on beat 1 ----------------
        beat(B0, 8'hFF, TU_OK, 1'b0);
        beat(B1, 8'h7F, TU_OK, 1'b1);
        idle();
        idle();
        chk("strb_last_err", {61'd0, last_err}, 64'd2);
        chk("strb_err_cnt",  {32'd0, err_cnt},  64'd2);

        // ---------------- single-beat packet ----------------
        beat(B0, 8'hFF, TU_OK, 1'b1);
        idle();
        idle();
        chk("short_last_err", {61'd0, last_err}, 64'd4);
        chk("short_err_cnt",  {32'd0, err_cnt},  64'd3);

        // ---------------- four-beat packet, garbage drained ----------------
        beat(B0, 8'hFF, TU_OK, 1'b0);
        beat(B1, 8'hFF, TU_OK, 1'b0);
        beat(64'h1234, 8'h00, TU_BAD, 1'b0);
        beat(64'h5678, 8'h01, TU_BAD, 1'b1);
        idle();
        idle();
        chk("long_last_err", {61'd0, last_err}, 64'd4);
        chk("long_err_cnt",  {32'd0, err_cnt},  64'd4);
        chk("long_pkt_cnt",  {32'd0, pkt_cnt},  64'd6);

        // ---------------- stalls between beats, then good ----------------
        beat(B0, 8'hFF, TU_OK, 1'b0);
        idle();
        idle();
        beat(B1, 8'hFF, TU_OK, 1'b1);
        idle();
        idle();
        chk("stall_good_cnt", {32'd0, good_cnt}, 64'd3);
        chk("stall_last_err_kept", {61'd0, last_err}, 64'd4);

        // ---------------- reset mid-packet ----------------
        beat(B0, 8'hFF, TU_OK, 1'b0);
        @(negedge clk_sys);
        tvalid = 1'b0;
        rst    = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        d0 = done_seen;
        good_pkt();
        idle();
        idle();
        chk("midrst_pulses",   done_seen - d0, 1);
        chk("midrst_pkt_cnt",  {32'd0, pkt_cnt},  64'd1);
        chk("midrst_good_cnt", {32'd0, good_cnt}, 64'd1);
        chk("midrst_err_cnt",  {32'd0, err_cnt},  64'd0);

        // ---------------- rst_cntrs coinciding with pkt_done ----------------
        good_pkt();
        idle();
        chk("rstc_pkt_done", {63'd0, pkt_done}, 64'd1);
        rst_cntrs = 1'b1;
        @(negedge clk_sys);
        rst_cntrs = 1'b0;
        idle();
        chk("rstc_pkt_cnt",  {32'd0, pkt_cnt},  64'd0);
        chk("rstc_good_cnt", {32'd0, good_cnt}, 64'd0);
        chk("rstc_err_cnt",  {32'd0, err_cnt},  64'd0);

        // ---------------- throttled instance ----------------
        @(negedge clk_sys);
        rst4 = 1'b0;
        #1 pat[0] = tready4;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk_sys);
            #1 pat[i] = tready4;
        end
        chk("thr_pattern", {56'd0, pat}, 64'h11);

        for (int p = 0; p < 4; p++) begin
            beat4(B0, TU_OK, 1'b0);
            beat4(B1, TU_OK, 1'b1);
        end
        @(negedge clk_sys);
        tvalid4 = 1'b0;
        tlast4  = 1'b0;
        repeat (4) @(negedge clk_sys);
        chk("thr_done_pulses", done4_seen, 4);
        chk("sat_pkt_cnt",  {62'd0, pkt_cnt4},  64'd3);
        chk("sat_good_cnt", {62'd0, good_cnt4}, 64'd3);
        chk("sat_err_cnt",  {62'd0, err_cnt4},  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
